debounce_sync: RTL and testbench



---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync_chain.sv | 39 +++
 rtl/debounce_sync.sv | 138 +++++++++++++
 tb/tb_debounce_sync.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the debounce_sync block: the 2-bit FSM state
// encoding and the saturation limit of the diagnostic bounce counter.
package debounce_pkg;

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  localparam logic [7:0] BOUNCE_MAX = 8'd255;

  typedef enum logic [1:0] {
    STATE_LOW       = ST_LOW,
    STATE_WAIT_HIGH = ST_WAIT_HIGH,
    STATE_HIGH      = ST_HIGH,
    STATE_WAIT_LOW  = ST_WAIT_LOW
  } state_e;

endpackage

// File: rtl/sync_chain.sv
// sync_chain
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Reusable for any asynchronous single-bit input.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, clears every stage to 0
//   d       - asynchronous input
//   q       - synchronised output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
// Synchronises a raw asynchronous level, filters contact bounce by requiring
// DEBOUNCE_CYCLES consecutive agreeing samples, and presents a clean
// registered level for the downstream edge detector.
// Ports:
//   clk        - sole clock
//   reset_n    - asynchronous active-low reset
//   x_raw      - raw asynchronous input
//   x_clean    - debounced level (registered)
//   busy       - high while a candidate level change is being qualified
//   bounce_cnt - saturating count of aborted transitions
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       x_raw,
  output logic       x_clean,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic x_sync;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (x_raw),
    .q       (x_sync)
  );

  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] bounce_q, bounce_d;
  logic       x_clean_q, x_clean_d;
  logic       busy_q, busy_d;
  logic       abort;

  // The counter holds how many consecutive samples have agreed with the
  // candidate level; the wait state is left for the new level on the sample
  // that makes DEBOUNCE_CYCLES in a row.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bounce_d = bounce_q;
    abort    = 1'b0;

    case (state_q)
      STATE_LOW: begin
        if (x_sync) begin
          state_d = STATE_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      STATE_WAIT_HIGH: begin
        if (!x_sync) begin
          state_d = STATE_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STATE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STATE_HIGH: begin
        if (!x_sync) begin
          state_d = STATE_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      STATE_WAIT_LOW: begin
        if (x_sync) begin
          state_d = STATE_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STATE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STATE_LOW;
        cnt_d   = '0;
      end
    endcase

    if (abort && (bounce_q != BOUNCE_MAX)) begin
      bounce_d = bounce_q + 8'd1;
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they describe.
    x_clean_d = (state_d == STATE_HIGH) || (state_d == STATE_WAIT_LOW);
    busy_d    = (state_d == STATE_WAIT_HIGH) || (state_d == STATE_WAIT_LOW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STATE_LOW;
      cnt_q     <= '0;
      bounce_q  <= '0;
      x_clean_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bounce_q  <= bounce_d;
      x_clean_q <= x_clean_d;
      busy_q    <= busy_d;
    end
  end

  assign x_clean    = x_clean_q;
  assign busy       = busy_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
// Self-checking bench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A behavioural model tracks the sample stream seen after the synchroniser
// delay and derives the clean level, busy flag and bounce count from run
// lengths of samples that disagree with the current clean level.
module tb_debounce_sync;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       x_raw = 1'b0;
  logic       x_clean;
  logic       busy;
  logic [7:0] bounce_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  bit done       = 1'b0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x_raw      (x_raw),
    .x_clean    (x_clean),
    .busy       (busy),
    .bounce_cnt (bounce_cnt)
  );

  // Behavioural model: raw samples emerge S edges later; a run of D samples
  // disagreeing with the clean level flips it, a shorter run counts a bounce.
  bit mdl_pipe [S];
  bit mdl_clean  = 1'b0;
  int mdl_run    = 0;
  int mdl_bounce = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < S; i++) mdl_pipe[i] = 1'b0;
        mdl_clean  = 1'b0;
        mdl_run    = 0;
        mdl_bounce = 0;
      end else begin
        bit vis;
        vis = mdl_pipe[S-1];
        for (int i = S-1; i > 0; i--) mdl_pipe[i] = mdl_pipe[i-1];
        mdl_pipe[0] = x_raw;
        if (vis != mdl_clean) begin
          mdl_run++;
          if (mdl_run == D) begin
            mdl_clean = vis;
            mdl_run   = 0;
          end
        end else begin
          if (mdl_run > 0 && mdl_bounce < 255) mdl_bounce++;
          mdl_run = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_cnt++;
    if (actual != expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives x_raw at the current (falling) edge and holds it for n sampling edges.
  task automatic applyStimulus(input bit v, input int n);
    x_raw = v;
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        checkOutput("cyc_x_clean", int'(x_clean), int'(mdl_clean));
        checkOutput("cyc_busy", int'(busy), (mdl_run > 0) ? 1 : 0);
        checkOutput("cyc_bounce_cnt", int'(bounce_cnt), mdl_bounce);
      end
    end
  end

  // Downstream rising/falling edge counting on x_clean.
  bit count_en  = 1'b0;
  bit prev_clean = 1'b0;
  int rises = 0;
  int falls = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (count_en) begin
        if (x_clean && !prev_clean) rises++;
        if (!x_clean && prev_clean) falls++;
      end
      prev_clean = x_clean;
    end
  end

  initial begin
    #2000000;
    fail_cnt++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_x_clean", int'(x_clean), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_bounce", int'(bounce_cnt), 0);
    reset_n = 1'b1;
    applyStimulus(0, 3);

    // Clean rise
    applyStimulus(1, 2);
    checkOutput("rise_busy_e2", int'(busy), 0);
    applyStimulus(1, 1);
    checkOutput("rise_busy_e3", int'(busy), 1);
    applyStimulus(1, 2);
    checkOutput("rise_clean_e5", int'(x_clean), 0);
    applyStimulus(1, 1);
    checkOutput("rise_clean_e6", int'(x_clean), 1);
    checkOutput("rise_busy_e6", int'(busy), 0);
    checkOutput("rise_bounce", int'(bounce_cnt), 0);
    checkOutput("model_rise_clean", int'(mdl_clean), 1);
    applyStimulus(1, 6);

    // Bouncy fall
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    applyStimulus(0, 5);
    checkOutput("fall_clean_e5", int'(x_clean), 1);
    applyStimulus(0, 1);
    checkOutput("fall_clean_e6", int'(x_clean), 0);
    checkOutput("fall_bounce", int'(bounce_cnt), 2);
    checkOutput("model_fall_bounce", mdl_bounce, 2);
    applyStimulus(0, 4);

    reset_n = 1'b0;
    applyStimulus(0, 2);
    reset_n = 1'b1;
    applyStimulus(0, 3);

    // Short pulse
    applyStimulus(1, 3);
    applyStimulus(0, 2);
    checkOutput("pulse_busy_e5", int'(busy), 1);
    applyStimulus(0, 1);
    checkOutput("pulse_busy_e6", int'(busy), 0);
    checkOutput("pulse_clean", int'(x_clean), 0);
    checkOutput("pulse_bounce", int'(bounce_cnt), 1);
    checkOutput("model_pulse_bounce", mdl_bounce, 1);

    // Reset in the middle of WAIT_HIGH
    applyStimulus(0, 4);
    applyStimulus(1, 4);
    checkOutput("mid_busy", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_clean", int'(x_clean), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_bounce", int'(bounce_cnt), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 5);
    checkOutput("rel_clean_e5", int'(x_clean), 0);
    applyStimulus(1, 1);
    checkOutput("rel_clean_e6", int'(x_clean), 1);
    checkOutput("rel_bounce", int'(bounce_cnt), 0);

    // Downstream integration: five bouncy presses
    applyStimulus(0, 10);
    count_en = 1'b1;
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1, 1);
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      applyStimulus(0, 1);
      applyStimulus(1, 8);
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      applyStimulus(0, 8);
    end
    count_en = 1'b0;
    checkOutput("press_rises", rises, 5);
    checkOutput("press_falls", falls, 5);

    // Randomised segments with occasional asynchronous resets
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        #($urandom_range(1, 4));
        reset_n = 1'b0;
        @(negedge clk);
        applyStimulus(1'($urandom_range(0, 1)), 1);
        reset_n = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end
    applyStimulus(0, 10);

    // Saturation of the bounce counter
    reset_n = 1'b0;
    applyStimulus(0, 2);
    reset_n = 1'b1;
    applyStimulus(0, 3);
    for (int p = 0; p < 300; p++) begin
      applyStimulus(1, 2);
      applyStimulus(0, 4);
      if (p == 199) begin
        checkOutput("sat_bounce_200", int'(bounce_cnt), 200);
        checkOutput("model_sat_200", mdl_bounce, 200);
      end
    end
    checkOutput("sat_bounce_300", int'(bounce_cnt), 255);
    checkOutput("model_sat_300", mdl_bounce, 255);
    checkOutput("sat_clean", int'(x_clean), 0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
